// File: rtl/dht11_sample_ctrl.sv
// Sample controller around the DHT11 reader: periodic start strobe, data capture,
// sequential binary-to-BCD conversion of both bytes, and no-response timeout flag.
module dht11_sample_ctrl #(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned PERIOD_MS   = 2000,
    parameter int unsigned TIMEOUT_MS  = 100,
    parameter int unsigned TRIG_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        data_rdy,
    input  logic [7:0]  temperature,
    input  logic [7:0]  humidity,
    output logic        sample_en,
    output logic [11:0] temp_bcd,
    output logic [11:0] hum_bcd,
    output logic        new_sample,
    output logic        sample_valid,
    output logic        timeout,
    output logic        busy
);

    // 64-bit products so large CLK_HZ * PERIOD_MS values do not overflow
    localparam longint unsigned PERIOD_CYC  = longint'(PERIOD_MS) * longint'(CLK_HZ) / 64'd1000;
    localparam longint unsigned TIMEOUT_CYC = longint'(TIMEOUT_MS) * longint'(CLK_HZ) / 64'd1000;
    localparam logic [31:0] PERIOD_TC  = 32'(PERIOD_CYC - 64'd1);
    localparam logic [31:0] TIMEOUT_TC = 32'(TIMEOUT_CYC);
    localparam logic [31:0] TRIG_LAST  = 32'(TRIG_CYCLES - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TRIG = 3'd1,
        S_WAIT = 3'd2,
        S_CONV = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] per_cnt_r;
    logic [31:0] tout_cnt_r;
    logic [31:0] trig_cnt_r;
    logic [2:0]  iter_cnt_r;
    logic        rdy_q_r;
    logic [7:0]  temp_sh_r;
    logic [7:0]  hum_sh_r;
    logic [11:0] temp_acc_r;
    logic [11:0] hum_acc_r;
    logic        sample_en_r;
    logic [11:0] temp_bcd_r;
    logic [11:0] hum_bcd_r;
    logic        new_sample_r;
    logic        sample_valid_r;
    logic        timeout_r;
    logic        busy_r;
    logic        rdy_edge_s;
    logic        tout_hit_s;

    // One double-dabble iteration: add 3 to every nibble >= 5, then shift in the next bit
    function automatic logic [11:0] dabble_step(input logic [11:0] acc, input logic bit_in);
        logic [11:0] adj;
        adj = acc;
        for (int n = 0; n < 3; n++) begin
            if (adj[n*4 +: 4] >= 4'd5) begin
                adj[n*4 +: 4] = adj[n*4 +: 4] + 4'd3;
            end else begin
                adj[n*4 +: 4] = adj[n*4 +: 4];
            end
        end
        return {adj[10:0], bit_in};
    endfunction

    assign rdy_edge_s = data_rdy & ~rdy_q_r;
    assign tout_hit_s = ((tout_cnt_r + 32'd1) == TIMEOUT_TC);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if ((per_cnt_r == PERIOD_TC) && enable) begin
                    state_s = S_TRIG;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_TRIG: begin
                if (trig_cnt_r == TRIG_LAST) begin
                    state_s = S_WAIT;
                end else begin
                    state_s = S_TRIG;
                end
            end
            S_WAIT: begin
                // a strobe arriving on the deadline cycle still counts as an answer
                if (rdy_edge_s) begin
                    state_s = S_CONV;
                end else if (tout_hit_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_CONV: begin
                if (iter_cnt_r == 3'd7) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_CONV;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Period, trigger-width, timeout and iteration counters plus data_rdy edge register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt_r  <= 32'd0;
            tout_cnt_r <= 32'd0;
            trig_cnt_r <= 32'd0;
            iter_cnt_r <= 3'd0;
            rdy_q_r    <= 1'b0;
        end else begin
            rdy_q_r <= data_rdy;
            if (state_r != S_IDLE || state_s != S_IDLE) begin
                per_cnt_r <= 32'd0;
            end else if (per_cnt_r != PERIOD_TC) begin
                per_cnt_r <= per_cnt_r + 32'd1;
            end else begin
                per_cnt_r <= per_cnt_r;
            end
            if (state_r == S_TRIG && state_s == S_TRIG) begin
                trig_cnt_r <= trig_cnt_r + 32'd1;
            end else begin
                trig_cnt_r <= 32'd0;
            end
            if (state_s == S_TRIG && state_r != S_TRIG) begin
                tout_cnt_r <= 32'd0;
            end else if (state_r == S_TRIG || state_r == S_WAIT) begin
                tout_cnt_r <= tout_cnt_r + 32'd1;
            end else begin
                tout_cnt_r <= 32'd0;
            end
            if (state_r == S_CONV) begin
                iter_cnt_r <= iter_cnt_r + 3'd1;
            end else begin
                iter_cnt_r <= 3'd0;
            end
        end
    end

    // Capture shift registers and BCD accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            temp_sh_r  <= 8'd0;
            hum_sh_r   <= 8'd0;
            temp_acc_r <= 12'd0;
            hum_acc_r  <= 12'd0;
        end else if (state_r == S_WAIT && rdy_edge_s) begin
            temp_sh_r  <= temperature;
            hum_sh_r   <= humidity;
            temp_acc_r <= 12'd0;
            hum_acc_r  <= 12'd0;
        end else if (state_r == S_CONV) begin
            temp_acc_r <= dabble_step(temp_acc_r, temp_sh_r[7]);
            hum_acc_r  <= dabble_step(hum_acc_r, hum_sh_r[7]);
            temp_sh_r  <= {temp_sh_r[6:0], 1'b0};
            hum_sh_r   <= {hum_sh_r[6:0], 1'b0};
        end else begin
            temp_sh_r  <= temp_sh_r;
            hum_sh_r   <= hum_sh_r;
            temp_acc_r <= temp_acc_r;
            hum_acc_r  <= hum_acc_r;
        end
    end

    // Registered outputs; both BCD words update together on leaving DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_en_r    <= 1'b0;
            busy_r         <= 1'b0;
            new_sample_r   <= 1'b0;
            temp_bcd_r     <= 12'd0;
            hum_bcd_r      <= 12'd0;
            sample_valid_r <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            sample_en_r  <= (state_s == S_TRIG);
            busy_r       <= (state_s != S_IDLE);
            new_sample_r <= (state_r == S_DONE);
            if (state_r == S_DONE) begin
                temp_bcd_r     <= temp_acc_r;
                hum_bcd_r      <= hum_acc_r;
                sample_valid_r <= 1'b1;
                timeout_r      <= 1'b0;
            end else if (state_r == S_WAIT && !rdy_edge_s && tout_hit_s) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    assign sample_en    = sample_en_r;
    assign temp_bcd     = temp_bcd_r;
    assign hum_bcd      = hum_bcd_r;
    assign new_sample   = new_sample_r;
    assign sample_valid = sample_valid_r;
    assign timeout      = timeout_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_dht11_sample_ctrl.sv
// Randomised self-checking bench for dht11_sample_ctrl; a timestamp-based model of the
// sample/capture/timeout schedule predicts every output on every cycle.
module tb_dht11_sample_ctrl;

    localparam int PER  = 20;
    localparam int TOUT = 10;
    localparam int TRIG = 4;
    localparam int LAT  = 9;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        data_rdy;
    logic [7:0]  temperature;
    logic [7:0]  humidity;
    logic        sample_en;
    logic [11:0] temp_bcd;
    logic [11:0] hum_bcd;
    logic        new_sample;
    logic        sample_valid;
    logic        timeout;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    dht11_sample_ctrl #(
        .CLK_HZ(1000), .PERIOD_MS(20), .TIMEOUT_MS(10), .TRIG_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .data_rdy(data_rdy),
        .temperature(temperature), .humidity(humidity), .sample_en(sample_en),
        .temp_bcd(temp_bcd), .hum_bcd(hum_bcd), .new_sample(new_sample),
        .sample_valid(sample_valid), .timeout(timeout), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: schedule expressed as timestamps (edge index of trigger, capture, idle entry)
    int          n = 0;
    int          idle_start = 0;
    int          t_trig = 0;
    int          cap_t = 0;
    bit          active = 0;
    bit          captured = 0;
    bit          m_rdy_prev = 0;
    logic [7:0]  lat_t, lat_h;
    logic [11:0] e_tbcd = 12'd0, e_hbcd = 12'd0;
    bit          e_sen = 0, e_busy = 0, e_new = 0, e_valid = 0, e_tout = 0;

    always @(posedge clk) begin
        bit rise;
        n++;
        if (!rst_n) begin
            idle_start = n; active = 0; captured = 0; m_rdy_prev = 0;
            e_tbcd = 12'd0; e_hbcd = 12'd0;
            e_sen = 0; e_busy = 0; e_new = 0; e_valid = 0; e_tout = 0;
        end else begin
            rise = data_rdy && !m_rdy_prev;
            m_rdy_prev = data_rdy;
            e_new = 0;
            if (!active) begin
                if (enable && (n - idle_start) >= PER) begin
                    active = 1; captured = 0; t_trig = n;
                end
            end else if (!captured) begin
                if (rise && (n - t_trig) > TRIG && (n - t_trig) <= TOUT) begin
                    captured = 1; cap_t = n; lat_t = temperature; lat_h = humidity;
                end else if ((n - t_trig) == TOUT) begin
                    e_tout = 1; active = 0; idle_start = n;
                end
            end else if ((n - cap_t) == LAT) begin
                e_tbcd = to_bcd(int'(lat_t)); e_hbcd = to_bcd(int'(lat_h));
                e_new = 1; e_valid = 1; e_tout = 0; active = 0; idle_start = n;
            end
            e_sen  = active && !captured && (n - t_trig) < TRIG;
            e_busy = active;
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        chk("sample_en",    32'(sample_en),    rst_n ? 32'(e_sen)   : 32'd0);
        chk("busy",         32'(busy),         rst_n ? 32'(e_busy)  : 32'd0);
        chk("new_sample",   32'(new_sample),   rst_n ? 32'(e_new)   : 32'd0);
        chk("sample_valid", 32'(sample_valid), rst_n ? 32'(e_valid) : 32'd0);
        chk("timeout",      32'(timeout),      rst_n ? 32'(e_tout)  : 32'd0);
        chk("temp_bcd",     32'(temp_bcd),     rst_n ? 32'(e_tbcd)  : 32'd0);
        chk("hum_bcd",      32'(hum_bcd),      rst_n ? 32'(e_hbcd)  : 32'd0);
    end

    task automatic wait_trigger();
        int k;
        k = 0;
        while (sample_en !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        chk("trigger_seen", 32'(sample_en), 32'd1);
        k = 0;
        while (sample_en === 1'b1 && k < 20) begin @(negedge clk); k++; end
    endtask

    task automatic deliver(input logic [7:0] t, input logic [7:0] h, input int d);
        repeat (d) @(negedge clk);
        temperature = t;
        humidity    = h;
        data_rdy    = 1'b1;
        @(negedge clk);
        data_rdy    = 1'b0;
    endtask

    task automatic wait_new(output int k);
        k = 0;
        while (new_sample !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        chk("new_sample_seen", 32'(new_sample), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, hi, se_cnt, ns_cnt, d;
        rst_n = 1'b0; enable = 1'b1; data_rdy = 1'b0; temperature = 8'd0; humidity = 8'd0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // first trigger 20 clocks after release, 4 clocks wide
        k = 0;
        while (sample_en !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        chk("first_trig_delay", 32'(k), 32'd20);
        chk("busy_on_trig", 32'(busy), 32'd1);
        hi = 0;
        while (sample_en === 1'b1 && hi < 50) begin hi++; @(negedge clk); end
        chk("trig_width", 32'(hi), 32'd4);

        deliver(8'd25, 8'd60, 0);
        wait_new(k);
        chk("latency", 32'(k), 32'd9);
        chk("t25", 32'(temp_bcd), 32'h025);
        chk("h60", 32'(hum_bcd), 32'h060);
        chk("valid_set", 32'(sample_valid), 32'd1);

        wait_trigger(); deliver(8'd255, 8'd0, 2); wait_new(k);
        chk("t255", 32'(temp_bcd), 32'h255);
        chk("h0", 32'(hum_bcd), 32'h000);

        // strobe on the deadline cycle must still be captured
        wait_trigger(); deliver(8'd99, 8'd100, 5); wait_new(k);
        chk("t99", 32'(temp_bcd), 32'h099);
        chk("h100", 32'(hum_bcd), 32'h100);

        // no answer: timeout 10 clocks after trigger, BCD held
        k = 0;
        while (sample_en !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        k = 0;
        while (timeout !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        chk("timeout_delay", 32'(k), 32'd10);
        chk("hold_t", 32'(temp_bcd), 32'h099);
        chk("hold_h", 32'(hum_bcd), 32'h100);

        wait_trigger(); deliver(8'd7, 8'd42, 1); wait_new(k);
        chk("timeout_cleared", 32'(timeout), 32'd0);
        chk("t7", 32'(temp_bcd), 32'h007);

        // enable low: no trigger; strobe in idle ignored
        enable = 1'b0; se_cnt = 0; ns_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            data_rdy = (i == 25);
            temperature = 8'd11; humidity = 8'd22;
            @(negedge clk);
            if (sample_en === 1'b1) se_cnt++;
            if (new_sample === 1'b1) ns_cnt++;
        end
        chk("en_low_no_trig", 32'(se_cnt), 32'd0);
        chk("idle_rdy_ignored", 32'(ns_cnt), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        chk("trig_on_enable", 32'(sample_en), 32'd1);
        k = 0;
        while (sample_en === 1'b1 && k < 20) begin @(negedge clk); k++; end
        deliver(8'd3, 8'd4, 0); wait_new(k);

        // reset during the conversion
        wait_trigger(); deliver(8'd200, 8'd150, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tbcd", 32'(temp_bcd), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        k = 0;
        while (sample_en !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        chk("trig_after_reset", 32'(k), 32'd20);
        k = 0;
        while (sample_en === 1'b1 && k < 20) begin @(negedge clk); k++; end
        deliver(8'd128, 8'd64, 0); wait_new(k);
        chk("t128", 32'(temp_bcd), 32'h128);

        // randomised transactions, including late strobes and strobes during conversion
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 30)) @(negedge clk);
                enable = 1'b1;
            end
            wait_trigger();
            d = int'($urandom_range(0, 7));
            deliver(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), d);
            if (d <= 5) begin
                if ($urandom_range(0, 1) == 1) begin
                    repeat (2) @(negedge clk);
                    data_rdy = 1'b1;
                    @(negedge clk);
                    data_rdy = 1'b0;
                end
                wait_new(k);
            end
        end
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
